// File: rtl/prim_esc_pkg.sv
// Shared types and helpers for the escalation sender array.
package prim_esc_pkg;

  typedef enum logic [1:0] {
    Idle  = 2'b00,
    EscHi = 2'b01,
    EscLo = 2'b10,
    Ping  = 2'b11
  } esc_state_e;

  localparam int unsigned PingLenDefault = 4;
  localparam int unsigned PingCntWDefault = $clog2(PingLenDefault);

  // Ping counter width; never narrower than one bit.
  function automatic int unsigned ping_cnt_w(int unsigned ping_len);
    return (ping_len > 2) ? $clog2(ping_len) : 1;
  endfunction

endpackage

// File: rtl/prim_esc_sender_array_if.sv
// Escalation sender array bundle: timer-side requests plus the diff wire pairs.
interface prim_esc_sender_array_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] ping_en_i;
  logic [N-1:0] esc_en_i;
  logic [N-1:0] esc_rx_p_i;
  logic [N-1:0] esc_rx_n_i;
  logic [N-1:0] clr_sticky_i;
  logic [N-1:0] esc_tx_p_o;
  logic [N-1:0] esc_tx_n_o;
  logic [N-1:0] ping_ok_o;
  logic [N-1:0] integ_fail_o;
  logic [N-1:0] integ_fail_sticky_o;

  modport master (
    output ping_en_i, esc_en_i, esc_rx_p_i, esc_rx_n_i, clr_sticky_i,
    input  esc_tx_p_o, esc_tx_n_o, ping_ok_o, integ_fail_o, integ_fail_sticky_o
  );

  modport slave (
    input  ping_en_i, esc_en_i, esc_rx_p_i, esc_rx_n_i, clr_sticky_i,
    output esc_tx_p_o, esc_tx_n_o, ping_ok_o, integ_fail_o, integ_fail_sticky_o
  );
endinterface

// File: rtl/prim_esc_sender_chan.sv
// One escalation sender channel: FSM, request delay flops, sticky fail bit, tx encode.
module prim_esc_sender_chan
  import prim_esc_pkg::*;
#(
  parameter int unsigned PingLen = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ping_en_i,
  input  logic esc_en_i,
  input  logic esc_rx_p_i,
  input  logic esc_rx_n_i,
  input  logic clr_sticky_i,
  output logic esc_tx_p_o,
  output logic esc_tx_n_o,
  output logic ping_ok_o,
  output logic integ_fail_o,
  output logic integ_fail_sticky_o
);

  localparam int unsigned CntW = ping_cnt_w(PingLen);
  localparam logic [CntW-1:0] CntMax = CntW'(PingLen - 1);

  if ((PingLen < 2) || ((PingLen % 2) != 0)) begin : gen_bad_ping_len
    $error("PingLen must be even and >= 2");
  end

  esc_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            esc_en_q, esc_en_q1, ping_en_q;
  logic            sticky_d, sticky_q;
  logic            resp, sigint, ping_exp;
  logic            integ_fail, ping_ok;

  assign resp     = esc_rx_p_i;
  assign sigint   = (esc_rx_p_i == esc_rx_n_i);
  // Receiver answers 1 on even check cycles, 0 on odd ones.
  assign ping_exp = ~cnt_q[0];

  // Next-state and raw fail/ok decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    integ_fail = sigint;
    ping_ok    = 1'b0;
    case (state_q)
      Idle: begin
        if (esc_en_i) begin
          state_d = EscHi;
        end else if (ping_en_i) begin
          state_d = Ping;
        end
        if (resp) integ_fail = 1'b1;
      end
      EscHi: begin
        if (esc_en_i && resp) begin
          state_d = EscLo;
        end else begin
          state_d    = Idle;
          integ_fail = sigint | ~resp;
        end
      end
      EscLo: begin
        if (esc_en_i && !resp) begin
          state_d = EscHi;
        end else begin
          state_d    = Idle;
          integ_fail = sigint | resp;
        end
      end
      Ping: begin
        if (esc_en_i) begin
          state_d = ping_exp ? EscLo : EscHi;
        end else if (resp != ping_exp) begin
          state_d    = Idle;
          integ_fail = 1'b1;
        end else if (cnt_q < CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d = Idle;
          ping_ok = ping_en_i;
        end
      end
      default: state_d = Idle;
    endcase

    // Keep the ping timer happy while an escalation is in flight.
    if ((esc_en_i | esc_en_q | esc_en_q1) & ping_en_i) ping_ok = 1'b1;

    // A collapsed diff pair invalidates everything else.
    if (sigint) begin
      ping_ok = 1'b0;
      state_d = Idle;
      cnt_d   = '0;
    end
  end

  assign ping_ok_o    = ping_ok & ~rst_i;
  assign integ_fail_o = integ_fail & ~rst_i;

  // Escalation level bypasses reset so a request is never masked.
  assign esc_tx_p_o = rst_i ? esc_en_i : (esc_en_i | esc_en_q | (ping_en_i & ~ping_en_q));
  assign esc_tx_n_o = ~esc_tx_p_o;

  // Failure wins over clear in the same cycle.
  assign sticky_d            = clr_sticky_i ? integ_fail_o : (sticky_q | integ_fail_o);
  assign integ_fail_sticky_o = sticky_q;

  // State, counter, delay and sticky registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      cnt_q     <= '0;
      esc_en_q  <= 1'b0;
      esc_en_q1 <= 1'b0;
      ping_en_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      esc_en_q  <= esc_en_i;
      esc_en_q1 <= esc_en_q;
      ping_en_q <= ping_en_i;
      sticky_q  <= sticky_d;
    end
  end

endmodule

// File: rtl/prim_esc_sender_array.sv
// N independent escalation sender channels behind one interface bundle.
module prim_esc_sender_array
  import prim_esc_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned PingLen = PingLenDefault
) (
  input logic                    clk_i,
  input logic                    rst_i,
  prim_esc_sender_array_if.slave bus
);

  if (N < 1) begin : gen_bad_n
    $error("N must be >= 1");
  end

  logic [N-1:0] tx_p, tx_n, ok, fail, sticky;

  for (genvar c = 0; c < N; c++) begin : gen_chan
    prim_esc_sender_chan #(
      .PingLen(PingLen)
    ) u_chan (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .ping_en_i          (bus.ping_en_i[c]),
      .esc_en_i           (bus.esc_en_i[c]),
      .esc_rx_p_i         (bus.esc_rx_p_i[c]),
      .esc_rx_n_i         (bus.esc_rx_n_i[c]),
      .clr_sticky_i       (bus.clr_sticky_i[c]),
      .esc_tx_p_o         (tx_p[c]),
      .esc_tx_n_o         (tx_n[c]),
      .ping_ok_o          (ok[c]),
      .integ_fail_o       (fail[c]),
      .integ_fail_sticky_o(sticky[c])
    );
  end

  assign bus.esc_tx_p_o          = tx_p;
  assign bus.esc_tx_n_o          = tx_n;
  assign bus.ping_ok_o           = ok;
  assign bus.integ_fail_o        = fail;
  assign bus.integ_fail_sticky_o = sticky;

endmodule
